// File: rtl/dma_arb_pkg.sv
// dma_arb_pkg: shared types and constants for the DMA stream arbiter.
//   state_t : arbiter FSM states
//   PL_W    : software priority level width
//   EPL_W   : effective priority width, {aged, pl}
//   sel_w   : stream-select width for a given stream count, never below 1
package dma_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_WORK} state_t;
  localparam int PL_W = 2;
  localparam int EPL_W = 3;
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dma_rr_prio_pick.sv
// dma_rr_prio_pick: combinational priority pick with round-robin tie-break.
//   elig_i   : per-stream eligible flags
//   epl_i    : per-stream effective priority, EPL_W bits each, stream 0 in the LSBs
//   rr_ptr_i : index where the cyclic tie-break scan starts
//   win_o    : winning stream index (0 when nothing is eligible)
//   found_o  : at least one stream is eligible
module dma_rr_prio_pick import dma_arb_pkg::*; #(
  parameter int NUMB_CH = 8,
  localparam int SEL_W = sel_w(NUMB_CH)
) (
  input  logic [NUMB_CH-1:0]       elig_i,
  input  logic [NUMB_CH*EPL_W-1:0] epl_i,
  input  logic [SEL_W-1:0]         rr_ptr_i,
  output logic [SEL_W-1:0]         win_o,
  output logic                     found_o
);
  logic [EPL_W-1:0] max_p;
  int rr;
  int d;
  int best_d;
  always_comb begin
    max_p = '0;
    found_o = 1'b0;
    for (int i = 0; i < NUMB_CH; i++)
      if (elig_i[i] && (!found_o || epl_i[i*EPL_W +: EPL_W] > max_p)) begin
        max_p = epl_i[i*EPL_W +: EPL_W];
        found_o = 1'b1;
      end
  end
  // Tie-break by cyclic distance from rr_ptr; constant indices keep the
  // scan free of variable-width selects.
  always_comb begin
    win_o = '0;
    rr = int'(rr_ptr_i);
    d = 0;
    best_d = NUMB_CH;
    for (int i = 0; i < NUMB_CH; i++) begin
      d = (i >= rr) ? i - rr : i + NUMB_CH - rr;
      if (elig_i[i] && epl_i[i*EPL_W +: EPL_W] == max_p && d < best_d) begin
        best_d = d;
        win_o = SEL_W'(i);
      end
    end
  end
endmodule

// File: rtl/dma_stream_arbiter_rr.sv
// dma_stream_arbiter_rr: picks one DMA stream per AHB transaction and holds
// the grant for the whole burst.
//   i_clk, i_nreset : clock, asynchronous active-low reset
//   i_en_stream     : per-stream enable
//   i_pl            : per-stream priority level, PL_W bits each, 3 = highest
//   i_request       : per-stream transaction ready
//   i_beats         : per-stream burst length, BEAT_W bits each, 0 means 1
//   i_master_ready  : master can take a new grant
//   i_beat_done     : master finished one beat of the granted burst
//   o_stream_sel    : granted stream
//   o_master_en     : grant active
//   o_txn_done      : pulse on the last beat of a burst
//   o_abort         : pulse when the granted stream is disabled mid-burst
module dma_stream_arbiter_rr import dma_arb_pkg::*; #(
  parameter int NUMB_CH = 8,
  parameter int BEAT_W  = 5,
  parameter int AGE_EN  = 1,
  parameter int AGE_MAX = 4,
  localparam int SEL_W = sel_w(NUMB_CH)
) (
  input  logic                      i_clk,
  input  logic                      i_nreset,
  input  logic [NUMB_CH-1:0]        i_en_stream,
  input  logic [NUMB_CH*PL_W-1:0]   i_pl,
  input  logic [NUMB_CH-1:0]        i_request,
  input  logic [NUMB_CH*BEAT_W-1:0] i_beats,
  input  logic                      i_master_ready,
  input  logic                      i_beat_done,
  output logic [SEL_W-1:0]          o_stream_sel,
  output logic                      o_master_en,
  output logic                      o_txn_done,
  output logic                      o_abort
);
  state_t                   state_q;
  logic [SEL_W-1:0]         sel_q;
  logic [SEL_W-1:0]         rr_ptr_q;
  logic [BEAT_W-1:0]        beat_cnt_q;
  logic                     master_en_q;
  logic [NUMB_CH-1:0]       eligible;
  logic [NUMB_CH-1:0]       aged;
  logic [NUMB_CH*EPL_W-1:0] epl;
  logic [SEL_W-1:0]         win;
  logic                     found;
  logic                     grant;
  logic                     sel_en;
  logic [BEAT_W-1:0]        win_beats;

  assign eligible = i_en_stream & i_request;
  assign grant = (state_q == ST_ARB) && i_master_ready && found;

  always_comb begin
    epl = '0;
    for (int i = 0; i < NUMB_CH; i++)
      epl[i*EPL_W +: EPL_W] = {aged[i], i_pl[i*PL_W +: PL_W]};
  end

  // Mux loops instead of variable selects so every stream count lints clean.
  always_comb begin
    win_beats = '0;
    sel_en = 1'b0;
    for (int i = 0; i < NUMB_CH; i++) begin
      if (win == SEL_W'(i)) win_beats = i_beats[i*BEAT_W +: BEAT_W];
      if (sel_q == SEL_W'(i)) sel_en = i_en_stream[i];
    end
  end

  dma_rr_prio_pick #(.NUMB_CH(NUMB_CH)) u_pick (
    .elig_i   (eligible),
    .epl_i    (epl),
    .rr_ptr_i (rr_ptr_q),
    .win_o    (win),
    .found_o  (found)
  );

  // Abort wins over a coincident last beat, so txn_done requires the stream enabled.
  assign o_abort = (state_q == ST_WORK) && !sel_en;
  assign o_txn_done = (state_q == ST_WORK) && sel_en && i_beat_done && beat_cnt_q == BEAT_W'(1);
  assign o_stream_sel = sel_q;
  assign o_master_en = master_en_q;

  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      state_q <= ST_IDLE;
      sel_q <= '0;
      rr_ptr_q <= '0;
      beat_cnt_q <= '0;
      master_en_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (|i_en_stream) state_q <= ST_ARB;
        ST_ARB: begin
          if (!(|i_en_stream)) state_q <= ST_IDLE;
          else if (grant) begin
            state_q <= ST_WORK;
            sel_q <= win;
            beat_cnt_q <= (win_beats == '0) ? BEAT_W'(1) : win_beats;
            rr_ptr_q <= (win == SEL_W'(NUMB_CH - 1)) ? '0 : win + SEL_W'(1);
            master_en_q <= 1'b1;
          end
        end
        ST_WORK: begin
          if (o_abort) begin
            state_q <= ST_ARB;
            master_en_q <= 1'b0;
          end else if (i_beat_done) begin
            beat_cnt_q <= beat_cnt_q - BEAT_W'(1);
            if (o_txn_done) begin
              state_q <= ST_ARB;
              master_en_q <= 1'b0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Age counts grant decisions a waiting stream has lost; it resets whenever
  // the stream stops being eligible, so disabled streams never age.
  if (AGE_EN != 0) begin : g_age
    for (genvar c = 0; c < NUMB_CH; c++) begin : g_ch
      logic [3:0] age_q;
      logic [3:0] age_d;
      always_comb
        age_d = !eligible[c] ? 4'd0 :
                !grant ? age_q :
                (win == SEL_W'(c)) ? 4'd0 :
                (age_q == 4'(AGE_MAX)) ? age_q : age_q + 4'd1;
      always_ff @(posedge i_clk or negedge i_nreset)
        if (!i_nreset) age_q <= '0;
        else age_q <= age_d;
      assign aged[c] = (age_q == 4'(AGE_MAX));
    end
  end else begin : g_no_age
    assign aged = '0;
  end
endmodule

// File: doc/dma_stream_arbiter_rr.md
Name: dma_stream_arbiter_rr

Overview:
Stream arbiter for the multi-stream AHB DMA. It sits between the per-stream FIFO/request logic and the single AHB master. It selects one stream per transaction using software priority, round-robin among equal priorities, and optional aging against starvation. It holds the grant for a whole burst, counted in beats acknowledged by the master.

Parameters:
NUMB_CH, 8, number of streams (1..16)
BEAT_W, 5, width of beat-count fields (max burst 16 beats)
AGE_EN, 1, 1 enables starvation aging, 0 disables it
AGE_MAX, 4, lost-grant count at which a waiting stream becomes "aged" (1..15)

Ports:
i_clk  in  1  clock
i_nreset  in  1  reset, asynchronous, active-low
i_en_stream  in  [NUMB_CH]x1  stream enabled
i_pl  in  [NUMB_CH]x2  software priority level, 3 = highest
i_request  in  [NUMB_CH]x1  stream has a transaction ready (FIFO threshold met)
i_beats  in  [NUMB_CH]xBEAT_W  beats in the stream's next transaction; 0 is treated as 1
i_master_ready  in  1  master idle, can accept a new grant
i_beat_done  in  1  master completed one beat of the granted transaction
o_stream_sel  out  SEL_W  granted stream, SEL_W = max(1,$clog2(NUMB_CH))
o_master_en  out  1  grant active, master may run
o_txn_done  out  1  one-cycle pulse on the last beat of a transaction
o_abort  out  1  one-cycle pulse when the granted stream is disabled mid-transaction

Behaviour:
- Reset values: o_stream_sel=0, o_master_en=0, o_txn_done=0, o_abort=0. Also rr_ptr=0, beat_cnt=0, all age counters=0, state=ST_IDLE. Reset mid-transaction drops the grant immediately and asynchronously.
- Eligibility: eligible[ch] = i_en_stream[ch] & i_request[ch].
- Effective priority is 3 bits: {aged[ch], i_pl[ch]}. aged[ch] = AGE_EN & (age[ch]==AGE_MAX). An aged stream beats any non-aged stream.
- Winner selection:
  - Find the maximum effective priority among eligible streams.
  - Among streams at that priority, the winner is the first index scanning cyclically from rr_ptr upward.
- FSM:
  - ST_IDLE -> ST_ARB when any i_en_stream is set.
  - ST_ARB -> ST_IDLE when no stream is enabled.
  - ST_ARB -> ST_WORK when i_master_ready=1 and any stream is eligible. In that cycle, register:
    - o_stream_sel = winner
    - beat_cnt = max(i_beats[winner], 1)
    - rr_ptr = (winner+1) mod NUMB_CH
  - ST_ARB stays in ST_ARB otherwise, with no register updates.
  - ST_WORK: o_master_en=1, registered, i.e. high in the first cycle after the grant decision.
    - On i_beat_done: beat_cnt decrements.
    - If beat_cnt==1 and i_beat_done: o_txn_done pulses in the same cycle (combinational from the state) and next state is ST_ARB.
  - ST_WORK -> ST_ARB with an o_abort pulse (same cycle, combinational) if i_en_stream[o_stream_sel]=0. No o_txn_done is issued. Abort has priority over a simultaneous last i_beat_done.
- Inter-transaction gap: minimum one cycle (WORK -> ARB -> WORK); o_master_en is low during ST_ARB.
- i_beat_done outside ST_WORK is ignored. i_request and i_beats changes during ST_WORK do not affect the current grant.
- Aging (AGE_EN=1):
  - On each grant decision, every eligible non-winning stream increments age, saturating at AGE_MAX.
  - The winner's age clears to 0.
  - A stream that is not eligible clears to 0 every cycle.
  - With AGE_EN=0, age registers are not generated and aged=0.
- Width rules: beat_cnt is BEAT_W bits. For NUMB_CH=1, o_stream_sel is constant 0 and rr_ptr is constant 0. For non-power-of-2 NUMB_CH, rr_ptr wraps from NUMB_CH-1 to 0.
- Disabled streams never win and never age.

Decomposition:
- Package dma_arb_pkg holds:
  - state enum {ST_IDLE, ST_ARB, ST_WORK}
  - PL_W=2 and EPL_W=3 constants
  - SEL_W function (max(1,$clog2(n)))
- One sub-module, dma_rr_prio_pick: purely combinational. Takes an eligible vector, effective-priority vector and rr_ptr; returns the winner index and a found flag. The FSM, beat counter and age counters stay in the top module.

Test Plan:
- Single beat: NUMB_CH=4, only ch2 enabled/requesting, i_beats=1, master_ready=1 -> sel=2, master_en high next cycle; one beat_done -> txn_done pulse, ARB; 1-cycle gap, regrant ch2.
- Priority: ch0 pl=1, ch3 pl=3, both requesting, i_beats=4 -> ch3 granted, master_en held for exactly 4 beat_done pulses with gaps; txn_done on the 4th.
- Round-robin: ch0, ch1, ch2 all pl=2, continuous requests, i_beats=1 -> grant order 0,1,2,0,1,2; rr_ptr wraps correctly for NUMB_CH=3.
- Aging: AGE_MAX=2; ch0 pl=3 always requesting, ch1 pl=0 requesting -> grants 0,0,1,0,0,1; with AGE_EN=0, ch1 is never granted.
- Abort: ch1 granted with i_beats=8; disable ch1 after 3 beats, in the same cycle as a beat_done -> o_abort pulse, no txn_done, master_en low next cycle, then ch0 is granted if eligible.
- Reset mid-burst: assert i_nreset=0 during ST_WORK -> all outputs 0 immediately; after release, state is ST_IDLE and rr_ptr=0.
